// File: rtl/text_line_renderer.sv
// text_line_renderer: double-buffered scanline fetch. It fetches text RAM and font ROM data into a back
// line buffer while the front buffer drives the pixel output.
module text_line_renderer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              LINE_START,
    input  logic [9:0]        ROW_NUM,
    input  logic [9:0]        PIXEL_CNTR,
    output logic [ADDR_W-1:0] TXT_ADDR,
    output logic              TXT_EN,
    input  logic [7:0]        TXT_DATA,
    output logic [7:0]        FONT_CHAR,
    output logic [3:0]        FONT_ROW,
    input  logic [7:0]        FONT_DATA,
    output logic              PIXEL_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              OVERRUN
);
    localparam int LINE_W = COLS * 8;
    localparam int CW     = $clog2(COLS);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t                 state_q, state_d;
    logic [1:0][LINE_W-1:0] line_buf;
    logic                   front_sel;
    logic [9:0]             row_q;
    logic [CW-1:0]          col_q, c1, c2;
    logic                   v1, v2, z1, z2;
    logic                   fin, issue, blank, wr_en;
    logic [7:0]             wr_byte;
    logic [ADDR_W-1:0]      addr_d;

    always_comb begin
        fin     = state_q == DRAIN && v2 && c2 == CW'(COLS - 1);
        issue   = state_q == FETCH && !LINE_START;
        blank   = row_q >= 10'(ROWS * 16);
        // a restart discards the in-flight column unless it is the line-completing write
        wr_en   = v2 && (!LINE_START || fin);
        addr_d  = ADDR_W'(row_q[9:4]) * ADDR_W'(COLS) + ADDR_W'(col_q);
        wr_byte = '0;
        for (int i = 0; i < 8; i++) wr_byte[i] = z2 ? 1'b0 : FONT_DATA[7 - i];
        state_d = LINE_START ? FETCH :
                  fin ? IDLE :
                  (state_q == FETCH && col_q == CW'(COLS - 1)) ? DRAIN : state_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            line_buf  <= '0;
            front_sel <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            c1        <= '0;
            c2        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            z1        <= 1'b0;
            z2        <= 1'b0;
            TXT_ADDR  <= '0;
            TXT_EN    <= 1'b0;
            FONT_CHAR <= '0;
            FONT_ROW  <= '0;
            PIXEL_OUT <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (LINE_START) begin
                front_sel <= ~front_sel;
                row_q     <= ROW_NUM;
                col_q     <= '0;
                OVERRUN   <= OVERRUN | (BUSY && !fin);
            end else if (issue) begin
                col_q <= col_q + 1'b1;
            end
            BUSY   <= LINE_START ? 1'b1 : fin ? 1'b0 : BUSY;
            DONE   <= fin;
            TXT_EN <= issue && !blank;
            if (issue && !blank) TXT_ADDR <= addr_d;
            v1 <= issue;
            z1 <= blank;
            c1 <= col_q;
            v2 <= v1 && !LINE_START;
            z2 <= z1;
            c2 <= c1;
            if (v1 && !z1) FONT_CHAR <= TXT_DATA;
            if (v1) FONT_ROW <= row_q[3:0];
            if (wr_en) line_buf[~front_sel][{c2, 3'b000} +: 8] <= wr_byte;
            PIXEL_OUT <= (PIXEL_CNTR < 10'(LINE_W)) ? line_buf[front_sel][PIXEL_CNTR] : 1'b0;
        end
    end
endmodule

// File: tb/tb_text_line_renderer.sv
// tb_text_line_renderer: directed scenarios for the scanline fetch stage with a constant text/font model.
module tb_text_line_renderer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        LINE_START = 1'b0;
    logic [9:0]  ROW_NUM = '0;
    logic [9:0]  PIXEL_CNTR = '0;
    logic [11:0] TXT_ADDR;
    logic        TXT_EN;
    logic [7:0]  TXT_DATA = 8'h48;
    logic [7:0]  FONT_CHAR;
    logic [3:0]  FONT_ROW;
    logic [7:0]  FONT_DATA = 8'hA5;
    logic        PIXEL_OUT, BUSY, DONE, OVERRUN;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  pat = 8'hA5;

    text_line_renderer #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .CLK(CLK), .RESET(RESET), .LINE_START(LINE_START), .ROW_NUM(ROW_NUM),
        .PIXEL_CNTR(PIXEL_CNTR), .TXT_ADDR(TXT_ADDR), .TXT_EN(TXT_EN), .TXT_DATA(TXT_DATA),
        .FONT_CHAR(FONT_CHAR), .FONT_ROW(FONT_ROW), .FONT_DATA(FONT_DATA),
        .PIXEL_OUT(PIXEL_OUT), .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // leaves time just after the edge that samples LINE_START (edge 0)
    task automatic strobe(input logic [9:0] row);
        @(negedge CLK);
        ROW_NUM = row;
        LINE_START = 1'b1;
        @(posedge CLK);
        #1;
        LINE_START = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        tick();
        tick();
        checks++;
        if ({BUSY, DONE, OVERRUN, TXT_EN, PIXEL_OUT} !== 5'b0 || TXT_ADDR !== 12'd0 || FONT_CHAR !== 8'd0 || FONT_ROW !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b ovr=%b en=%b pix=%b addr=%0d fc=%h fr=%0d want all 0",
                     BUSY, DONE, OVERRUN, TXT_EN, PIXEL_OUT, TXT_ADDR, FONT_CHAR, FONT_ROW);
        end
        @(negedge CLK);
        RESET = 1'b1;
        for (int p = 0; p < 800; p++) begin
            @(negedge CLK);
            PIXEL_CNTR = 10'(p);
            tick();
            checks++;
            if (PIXEL_OUT !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL idle_pixel p=%0d pix=%b busy=%b done=%b ovr=%b want 0", p, PIXEL_OUT, BUSY, DONE, OVERRUN);
            end
        end
    endtask

    task automatic test_fetch_row0();
        strobe(10'd0);
        for (int k = 1; k <= 90; k++) begin
            tick();
            checks++;
            if (TXT_EN !== (k <= 80)) begin
                failures++;
                $display("FAIL row0_txt_en k=%0d got=%b want=%b", k, TXT_EN, k <= 80);
            end
            if (k <= 80) begin
                checks++;
                if (TXT_ADDR !== 12'(k - 1)) begin
                    failures++;
                    $display("FAIL row0_addr k=%0d got=%0d want=%0d", k, TXT_ADDR, k - 1);
                end
            end
            checks++;
            if (DONE !== (k == 82) || BUSY !== (k < 82)) begin
                failures++;
                $display("FAIL row0_done_busy k=%0d done=%b busy=%b want done=%b busy=%b", k, DONE, BUSY, k == 82, k < 82);
            end
        end
        checks++;
        if (FONT_CHAR !== 8'h48 || FONT_ROW !== 4'd0) begin
            failures++;
            $display("FAIL row0_font fc=%h fr=%0d want 48/0", FONT_CHAR, FONT_ROW);
        end
    endtask

    task automatic test_display();
        strobe(10'd0);
        for (int p = 0; p < 800; p++) begin
            @(negedge CLK);
            PIXEL_CNTR = 10'(p);
            tick();
            checks++;
            if (PIXEL_OUT !== ((p < 640) ? pat[7 - (p % 8)] : 1'b0)) begin
                failures++;
                $display("FAIL display p=%0d got=%b want=%b", p, PIXEL_OUT, (p < 640) ? pat[7 - (p % 8)] : 1'b0);
            end
        end
    endtask

    task automatic test_row37();
        strobe(10'd37);
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k <= 80) begin
                checks++;
                if (TXT_EN !== 1'b1 || TXT_ADDR !== 12'(159 + k)) begin
                    failures++;
                    $display("FAIL row37_addr k=%0d en=%b got=%0d want=%0d", k, TXT_EN, TXT_ADDR, 159 + k);
                end
            end
            if (k >= 2) begin
                checks++;
                if (FONT_ROW !== 4'd5) begin
                    failures++;
                    $display("FAIL row37_font_row k=%0d got=%0d want=5", k, FONT_ROW);
                end
            end
            checks++;
            if (DONE !== (k == 82)) begin
                failures++;
                $display("FAIL row37_done k=%0d got=%b want=%b", k, DONE, k == 82);
            end
        end
    endtask

    task automatic test_blank();
        strobe(10'd490);
        for (int k = 1; k <= 90; k++) begin
            tick();
            checks++;
            if (TXT_EN !== 1'b0 || DONE !== (k == 82)) begin
                failures++;
                $display("FAIL blank_fetch k=%0d en=%b done=%b want en=0 done=%b", k, TXT_EN, DONE, k == 82);
            end
        end
        strobe(10'd0);
        for (int p = 0; p < 800; p++) begin
            @(negedge CLK);
            PIXEL_CNTR = 10'(p);
            tick();
            checks++;
            if (PIXEL_OUT !== 1'b0) begin
                failures++;
                $display("FAIL blank_display p=%0d got=%b want=0", p, PIXEL_OUT);
            end
        end
    endtask

    task automatic test_overrun();
        strobe(10'd16);
        for (int k = 1; k <= 39; k++) begin
            tick();
            checks++;
            if (DONE !== 1'b0 || OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL ovr_first_line k=%0d done=%b ovr=%b want 0/0", k, DONE, OVERRUN);
            end
        end
        checks++;
        if (TXT_ADDR !== 12'd118) begin
            failures++;
            $display("FAIL ovr_mid_addr got=%0d want=118", TXT_ADDR);
        end
        strobe(10'd32);
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k <= 80) begin
                checks++;
                if (TXT_EN !== 1'b1 || TXT_ADDR !== 12'(159 + k)) begin
                    failures++;
                    $display("FAIL ovr_restart_addr k=%0d en=%b got=%0d want=%0d", k, TXT_EN, TXT_ADDR, 159 + k);
                end
            end
            checks++;
            if (DONE !== (k == 82) || OVERRUN !== 1'b1) begin
                failures++;
                $display("FAIL ovr_done k=%0d done=%b ovr=%b want done=%b ovr=1", k, DONE, OVERRUN, k == 82);
            end
        end
    endtask

    task automatic test_reset_mid();
        strobe(10'd0);
        for (int k = 1; k <= 50; k++) tick();
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, OVERRUN, TXT_EN, PIXEL_OUT} !== 5'b0 || TXT_ADDR !== 12'd0 || FONT_CHAR !== 8'd0 || FONT_ROW !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b ovr=%b en=%b pix=%b addr=%0d fc=%h fr=%0d want all 0",
                     BUSY, DONE, OVERRUN, TXT_EN, PIXEL_OUT, TXT_ADDR, FONT_CHAR, FONT_ROW);
        end
        @(negedge CLK);
        RESET = 1'b1;
        strobe(10'd16);
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k <= 80) begin
                checks++;
                if (TXT_EN !== 1'b1 || TXT_ADDR !== 12'(79 + k)) begin
                    failures++;
                    $display("FAIL post_reset_addr k=%0d en=%b got=%0d want=%0d", k, TXT_EN, TXT_ADDR, 79 + k);
                end
            end
            checks++;
            if (DONE !== (k == 82) || OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_done k=%0d done=%b ovr=%b want done=%b ovr=0", k, DONE, OVERRUN, k == 82);
            end
        end
    endtask

    task automatic test_back_to_back();
        strobe(10'd0);
        for (int k = 1; k <= 81; k++) tick();
        strobe(10'd16);
        checks++;
        if (DONE !== 1'b1 || OVERRUN !== 1'b0 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL b2b_edge done=%b ovr=%b busy=%b want 1/0/1", DONE, OVERRUN, BUSY);
        end
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k <= 80) begin
                checks++;
                if (TXT_EN !== 1'b1 || TXT_ADDR !== 12'(79 + k)) begin
                    failures++;
                    $display("FAIL b2b_addr k=%0d en=%b got=%0d want=%0d", k, TXT_EN, TXT_ADDR, 79 + k);
                end
            end
            checks++;
            if (DONE !== (k == 82) || OVERRUN !== 1'b0) begin
                failures++;
                $display("FAIL b2b_done k=%0d done=%b ovr=%b want done=%b ovr=0", k, DONE, OVERRUN, k == 82);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_row0();
        test_display();
        test_row37();
        test_blank();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_line_renderer.md
# text_line_renderer

Scanline fetch stage between the character/font sources and the VGA pixel outputs. On each line-start strobe the block swaps its two 640-bit line buffers. It then fills the back buffer for the requested scanline by walking the 80 text columns, reading character codes from text RAM and glyph rows from the font ROM. Meanwhile it serves the front buffer to the RED/GREEN/BLUE drive, indexed by the controller's pixel counter.

## Interface
- COLS, 80: text columns per line (640 / 8-pixel glyphs)
- ROWS, 30: text rows per frame (480 / 16-line glyphs)
- ADDR_W, 12: text RAM address width

- CLK  in  1  25 MHz pixel clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- LINE_START  in  1  single-cycle strobe: swap buffers, begin fetch for ROW_NUM
- ROW_NUM  in  10  scanline to fetch (0..524); sampled only on LINE_START
- PIXEL_CNTR  in  10  current display pixel (0..799)
- TXT_ADDR  out  ADDR_W  text RAM read address
- TXT_EN  out  1  text RAM read enable
- TXT_DATA  in  8  character code, valid 1 cycle after TXT_ADDR/TXT_EN
- FONT_CHAR  out  8  character code to font ROM
- FONT_ROW  out  4  glyph row (ROW_NUM[3:0])
- FONT_DATA  in  8  glyph row bits, valid 1 cycle after FONT_CHAR/FONT_ROW; bit 7 = leftmost pixel
- PIXEL_OUT  out  1  front-buffer pixel for PIXEL_CNTR, registered
- BUSY  out  1  fetch in progress
- DONE  out  1  one-cycle pulse when the back buffer is complete
- OVERRUN  out  1  sticky: LINE_START arrived while BUSY

## Operation
- Reset values: PIXEL_OUT=0, BUSY=0, DONE=0, OVERRUN=0, TXT_EN=0, TXT_ADDR=0, FONT_CHAR=0, FONT_ROW=0, both buffers all-zero, front select=0, state IDLE.
- States: IDLE, FETCH, DRAIN.
- IDLE: on LINE_START, toggle front select, latch row=ROW_NUM, col=0, go to FETCH.
- FETCH (one column per cycle): drive TXT_EN=1 and TXT_ADDR = (row>>4)*COLS + col. Truncate to ADDR_W; 30*80-1=2399 fits. When col reaches COLS-1, go to DRAIN.
- Pipeline stage 2: register TXT_DATA to FONT_CHAR and row[3:0] to FONT_ROW, plus a valid bit and column tag.
- Pipeline stage 3: write FONT_DATA into back buffer pixels col*8 .. col*8+7. FONT_DATA[7] goes to pixel col*8; FONT_DATA[0] goes to pixel col*8+7.
- DRAIN: wait for the last two pipeline stages to finish. When the column-79 write completes, pulse DONE, clear BUSY, return to IDLE.
- BUSY is high from the cycle after LINE_START until the cycle DONE pulses.
- Blank rows (latched row >= ROWS*16): no TXT_EN. Write the back buffer with zeros, one column per cycle, on the same schedule so that DONE timing is identical.
- LINE_START while BUSY: set OVERRUN (held until reset). Flush the pipeline valid bits, swap buffers anyway, restart at col=0 with the new ROW_NUM. No DONE pulse for the aborted line.
- Display: PIXEL_OUT <= front[PIXEL_CNTR] when PIXEL_CNTR < 640, else 0. The front buffer is never written.
- A line fetched after LINE_START k is displayed after LINE_START k+1.

## Timing
- LINE_START sampled at edge 0.
- First TXT_EN/TXT_ADDR (col 0) at edge 1.
- Col 79 address at edge 80.
- Last buffer write at edge 82.
- DONE high in the cycle after edge 82, i.e. 82 cycles of latency. This is well within the 800-cycle line period.
- TXT_EN is high for exactly 80 consecutive cycles per non-blank line.
- PIXEL_OUT latency: 1 cycle from PIXEL_CNTR.
- LINE_START in the same cycle as the DONE-producing write: the write completes, DONE pulses, no OVERRUN, and the new fetch starts normally.
- Reset mid-fetch: immediate return to the reset values above; the in-flight line is discarded.

## Test plan
- Reset then idle: PIXEL_OUT=0 for PIXEL_CNTR 0..799; BUSY=DONE=OVERRUN=0.
- LINE_START with ROW_NUM=0, text model returns 8'h48, font returns 8'hA5: TXT_ADDR steps 0..79 on edges 1..80 and DONE pulses after 82 cycles. After the next LINE_START, PIXEL_OUT follows 1,0,1,0,0,1,0,1 repeating across 0..639, then 0 for 640..799.
- ROW_NUM=37: TXT_ADDR runs 160..239 and FONT_ROW=5 throughout.
- ROW_NUM=490: TXT_EN never asserts, DONE still arrives after 82 cycles, and the displayed line is all zeros.
- Second LINE_START 40 cycles after the first: OVERRUN=1 and stays set. Exactly one DONE, 82 cycles after the second strobe. TXT_ADDR restarts at the new row base.
- RESET asserted at cycle 50 of a fetch: all outputs return to their reset values on the same edge. A subsequent LINE_START fetches normally.
